// File: rtl/tow_round_ctrl_if.sv
// Player/difficulty inputs and scoreboard/rope outputs of the tug-of-war round controller.
// No valid/ready handshake: key and diff are levels sampled every clock, outputs are always current.
interface tow_round_ctrl_if;
  logic       key;
  logic [9:0] diff;
  logic [8:0] leds;
  logic [2:0] player_score;
  logic [2:0] comp_score;
  logic       game_over;
  logic [1:0] dbg_state;

  modport master (
    output key, diff,
    input  leds, player_score, comp_score, game_over, dbg_state
  );

  modport slave (
    input  key, diff,
    output leds, player_score, comp_score, game_over, dbg_state
  );
endinterface

// File: rtl/tow_round_ctrl.sv
// Tug-of-war round controller: synchronized player button vs. LFSR-driven computer pulls,
// moving a one-hot rope marker over 9 LEDs and keeping per-side round scores.
module tow_round_ctrl #(
  parameter int TICK_DIV    = 1024,
  parameter int HOLD_CYCLES = 1024
) (
  input logic            clk,
  input logic            reset,
  tow_round_ctrl_if.slave bus
);

  localparam logic [1:0] ST_PLAY = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0]    POS_MID   = 4'd4;
  localparam logic [3:0]    POS_TOP   = 4'd8;
  localparam logic [2:0]    SCORE_PRE_WIN = 3'd6;

  logic          s1, s2, s3;
  logic [TW-1:0] tick_cnt;
  logic [9:0]    lfsr;
  logic [1:0]    state, state_nx;
  logic [3:0]    pos, pos_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [2:0]    p_score, p_score_nx;
  logic [2:0]    c_score, c_score_nx;
  logic          player_press, tick, comp_press;

  // Button is asynchronous: two flops to settle, a third to find the falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= bus.key;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign player_press = ~s2 & s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= 10'h001;
    end else if (tick) begin
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end
  end

  // Pull decision uses the LFSR value before this tick's shift.
  assign comp_press = tick & (lfsr <= bus.diff);

  always_comb begin
    state_nx   = state;
    pos_nx     = pos;
    hold_nx    = hold_cnt;
    p_score_nx = p_score;
    c_score_nx = c_score;
    case (state)
      ST_PLAY: begin
        if (player_press && !comp_press) begin
          if (pos == POS_TOP) begin
            p_score_nx = p_score + 3'd1;
            if (p_score == SCORE_PRE_WIN) begin
              state_nx = ST_OVER;
            end else begin
              state_nx = ST_HOLD;
              hold_nx  = HOLD_LOAD;
            end
          end else begin
            pos_nx = pos + 4'd1;
          end
        end else if (comp_press && !player_press) begin
          if (pos == 4'd0) begin
            c_score_nx = c_score + 3'd1;
            if (c_score == SCORE_PRE_WIN) begin
              state_nx = ST_OVER;
            end else begin
              state_nx = ST_HOLD;
              hold_nx  = HOLD_LOAD;
            end
          end else begin
            pos_nx = pos - 4'd1;
          end
        end
      end
      ST_HOLD: begin
        if (hold_cnt == '0) begin
          state_nx = ST_PLAY;
          pos_nx   = POS_MID;
        end else begin
          hold_nx = hold_cnt - 1'b1;
        end
      end
      ST_OVER: begin
        state_nx = ST_OVER;
      end
      default: begin
        state_nx = ST_PLAY;
        pos_nx   = POS_MID;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_PLAY;
      pos      <= POS_MID;
      hold_cnt <= '0;
      p_score  <= 3'd0;
      c_score  <= 3'd0;
    end else begin
      state    <= state_nx;
      pos      <= pos_nx;
      hold_cnt <= hold_nx;
      p_score  <= p_score_nx;
      c_score  <= c_score_nx;
    end
  end

  // Outputs decode registered state only, so key/diff never reach them combinationally.
  always_comb begin
    bus.leds = 9'd0;
    if (state == ST_PLAY) begin
      bus.leds = 9'd1 << pos;
    end
  end

  assign bus.player_score = p_score;
  assign bus.comp_score   = c_score;
  assign bus.game_over    = (state == ST_OVER);
  assign bus.dbg_state    = state;

endmodule
